pap_table_write_scheduler: RTL and testbench
============================================

Name: pap_table_write_scheduler

Overview:
- Sequences all writes into one PAp predictor table (counter table or per-address history table), which has a single physical write port.
- Runs the power-up/flush initialization sweep.
- Arbitrates NUM_REQ concurrent update requesters (branch-result / history-recovery lanes).
- Buffers conflicting writes in a small coalescing queue.
- Sits between the branch-result path and the BlockMultiPortRAM write port.

Parameters:
- ENTRY_NUM, 1024, table entries (power of two).
- INDEX_W, 10, index width = log2(ENTRY_NUM).
- DATA_W, 16, entry width.
- NUM_REQ, 2, update requesters per cycle.
- QUEUE_DEPTH, 4, pending-write slots (≥ NUM_REQ).
- INIT_VALUE, 16'h0000, value written by the init sweep.

Ports:
- clk  in  1  clock.
- rstN  in  1  reset, asynchronous, active-low.
- initStart  in  1  pulse: flush queue and re-run init sweep.
- initBusy  out  1  high while sweeping.
- reqValid  in  NUM_REQ  per-lane write request.
- reqIndex  in  NUM_REQ*INDEX_W  per-lane target index (lane i at bits [i*INDEX_W +: INDEX_W]).
- reqData  in  NUM_REQ*DATA_W  per-lane write value.
- reqReady  out  1  all lanes may present this cycle.
- wrEn  out  1  RAM write enable.
- wrIndex  out  INDEX_W  RAM write address.
- wrData  out  DATA_W  RAM write value.
- queueCount  out  clog2(QUEUE_DEPTH+1)  occupied slots.

Behaviour:
- FSM states: INIT, RUN.
- Reset (rstN=0, async):
  - state=INIT, sweep index=0, queue empty.
  - Outputs: wrEn=0, wrIndex=0, wrData=0, reqReady=0, initBusy=1, queueCount=0.
- INIT:
  - Each cycle: wrEn=1, wrIndex=sweep, wrData=INIT_VALUE, sweep+1.
  - When sweep=ENTRY_NUM-1 the write occurs, then next state is RUN. The sweep takes exactly ENTRY_NUM cycles.
  - reqReady=0 and initBusy=1 throughout; requests are ignored.
- RUN:
  - initBusy=0.
  - reqReady = (QUEUE_DEPTH - queueCount ≥ NUM_REQ), from registered count only (no combinational path from reqValid).
- Accept: lane i is accepted iff reqValid[i] && reqReady. When reqReady=0, valid requests are dropped and never written.
- Write-port selection, one write per cycle:
  - Queue non-empty: pop head → wrIndex/wrData, wrEn=1.
  - Queue empty: lowest-numbered accepted lane bypasses directly to the port in the same cycle (zero latency).
  - Nothing pending: wrEn=0; wrIndex/wrData hold their last values.
- Enqueue: accepted lanes not bypassed enter the queue in lane order. Lower lane = older.
- Coalescing:
  - An accepted lane whose index matches a queued entry other than the head being popped this cycle overwrites that entry's data in place (no new slot).
  - Two lanes with the same index in one cycle: only the higher lane is stored.
  - A lane matching the entry written this cycle (popped head or bypass) is enqueued normally, so the later value lands last.
- Ordering: for any index, the RAM's final value equals the value from the youngest accepted request.
- Counts:
  - queueCount next = count + enqueued - popped.
  - Never exceeds QUEUE_DEPTH; guaranteed by the reqReady rule.
  - Read/write pointers wrap modulo QUEUE_DEPTH.
- initStart in RUN:
  - Next cycle: queue cleared (pending writes discarded), sweep=0, state=INIT.
  - Requests accepted in the initStart cycle are discarded.
  - The write port behaves normally in the initStart cycle.
- initStart in INIT: restarts sweep at 0.
- Reset mid-sweep or mid-queue: immediate return to reset state.

Optional Feature:
- Macro: PAP_SCHED_STATS_EN.
- When defined, adds output coalesceCount (16 bits, saturating at 16'hFFFF). It increments by the number of lanes coalesced each cycle (both in-queue overwrites and same-cycle duplicate lanes). It clears on reset and on initStart.
- When undefined, the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset release, ENTRY_NUM=16 → wrEn=1 for cycles 0..15 with wrIndex 0..15 and wrData=INIT_VALUE; cycle 16 initBusy=0, reqReady=1, wrEn=0.
- RUN, empty queue, lane0 {idx 5, 0xAAAA} + lane1 {idx 9, 0xBBBB} → same cycle write idx 5/0xAAAA; next cycle idx 9/0xBBBB; queueCount 1 → 0.
- Both lanes on idx 3 (0x1111, 0x2222) for 3 consecutive cycles → final RAM idx 3 = 0x2222; queueCount never exceeds 3; wrEn stays high until the queue drains.
- Fill the queue with distinct indices until queueCount=3 (DEPTH 4) → reqReady=0; lanes held valid are dropped; reqReady returns 1 once queueCount ≤ 2.
- Queue holds idx 7=0x0001 (not head); new lane0 idx 7=0x0002 → queueCount unchanged; idx 7 written once with 0x0002 (stats build: coalesceCount=1).
- initStart with queueCount=2 → next cycle queueCount=0, initBusy=1; queued writes never appear; sweep restarts at idx 0.

Source files
------------

// File: rtl/pap_table_write_scheduler.sv
// PAp table write scheduler: init sweep, lane arbitration, coalescing write queue.
// Define PAP_SCHED_STATS_EN to add the saturating coalesceCount output.
module pap_table_write_scheduler #(
    parameter int ENTRY_NUM = 1024,
    parameter int INDEX_W = 10,
    parameter int DATA_W = 16,
    parameter int NUM_REQ = 2,
    parameter int QUEUE_DEPTH = 4,
    parameter logic [DATA_W-1:0] INIT_VALUE = '0
) (
    input  logic                               clk,
    input  logic                               rstN,
    input  logic                               initStart,
    output logic                               initBusy,
    input  logic [NUM_REQ-1:0]                 reqValid,
    input  logic [NUM_REQ*INDEX_W-1:0]         reqIndex,
    input  logic [NUM_REQ*DATA_W-1:0]          reqData,
    output logic                               reqReady,
    output logic                               wrEn,
    output logic [INDEX_W-1:0]                 wrIndex,
    output logic [DATA_W-1:0]                  wrData,
`ifdef PAP_SCHED_STATS_EN
    output logic [15:0]                        coalesceCount,
`endif
    output logic [$clog2(QUEUE_DEPTH+1)-1:0]   queueCount
);
    localparam int CNT_W = $clog2(QUEUE_DEPTH + 1);
    localparam int PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;

    typedef enum logic {INIT, RUN} state_t;

    state_t               state;
    logic [INDEX_W-1:0]   sweep;
    logic [PTR_W-1:0]     rd_ptr;
    logic [CNT_W-1:0]     count;
    logic [INDEX_W-1:0]   q_idx  [QUEUE_DEPTH];
    logic [DATA_W-1:0]    q_data [QUEUE_DEPTH];
    logic [INDEX_W-1:0]   last_idx;
    logic [DATA_W-1:0]    last_data;

    logic [INDEX_W-1:0]   lane_idx   [NUM_REQ];
    logic [DATA_W-1:0]    lane_data  [NUM_REQ];
    logic [PTR_W-1:0]     merge_slot [NUM_REQ];
    logic [PTR_W-1:0]     alloc_slot [NUM_REQ];
    logic [NUM_REQ-1:0]   acc, byp, cand, store, merge;
    logic [CNT_W-1:0]     n_alloc;
    logic [PTR_W-1:0]     slot;
    logic                 pop;
    logic                 found;

    assign initBusy   = (state == INIT);
    assign queueCount = count;
    assign reqReady   = (state == RUN) &&
                        ((CNT_W'(QUEUE_DEPTH) - count) >= CNT_W'(NUM_REQ));

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            lane_idx[i]  = reqIndex[i*INDEX_W +: INDEX_W];
            lane_data[i] = reqData[i*DATA_W +: DATA_W];
        end
    end

    always_comb begin
        acc   = reqValid & {NUM_REQ{reqReady}};
        pop   = (state == RUN) && (count != '0);
        byp   = '0;
        found = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!pop && acc[i] && !found) begin
                byp[i] = 1'b1;
                found  = 1'b1;
            end
        end
        cand  = acc & ~byp;
        store = cand;
        for (int i = 0; i < NUM_REQ; i++)
            for (int j = i + 1; j < NUM_REQ; j++)
                if (cand[j] && lane_idx[j] == lane_idx[i])
                    store[i] = 1'b0;
        // The head is always popped when present, so only offsets 1.. may merge.
        slot = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            merge[i]      = 1'b0;
            merge_slot[i] = '0;
            for (int k = 1; k < QUEUE_DEPTH; k++) begin
                slot = PTR_W'((int'(rd_ptr) + k) % QUEUE_DEPTH);
                if (store[i] && k < int'(count) && q_idx[slot] == lane_idx[i]) begin
                    merge[i]      = 1'b1;
                    merge_slot[i] = slot;
                end
            end
        end
        n_alloc = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            alloc_slot[i] = PTR_W'((int'(rd_ptr) + int'(count)
                                    + int'(n_alloc)) % QUEUE_DEPTH);
            if (store[i] && !merge[i])
                n_alloc = n_alloc + CNT_W'(1);
        end
    end

    always_comb begin
        wrEn    = 1'b0;
        wrIndex = last_idx;
        wrData  = last_data;
        if (state == INIT) begin
            if (rstN) begin
                wrEn    = 1'b1;
                wrIndex = sweep;
                wrData  = INIT_VALUE;
            end
        end else if (pop) begin
            wrEn    = 1'b1;
            wrIndex = q_idx[rd_ptr];
            wrData  = q_data[rd_ptr];
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (byp[i]) begin
                    wrEn    = 1'b1;
                    wrIndex = lane_idx[i];
                    wrData  = lane_data[i];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state     <= INIT;
            sweep     <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            last_idx  <= '0;
            last_data <= '0;
            for (int k = 0; k < QUEUE_DEPTH; k++) begin
                q_idx[k]  <= '0;
                q_data[k] <= '0;
            end
        end else begin
            if (wrEn) begin
                last_idx  <= wrIndex;
                last_data <= wrData;
            end
            if (initStart) begin
                state  <= INIT;
                sweep  <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else if (state == INIT) begin
                sweep <= sweep + INDEX_W'(1);
                if (sweep == INDEX_W'(ENTRY_NUM - 1))
                    state <= RUN;
            end else begin
                for (int i = 0; i < NUM_REQ; i++) begin
                    if (merge[i]) begin
                        q_data[merge_slot[i]] <= lane_data[i];
                    end else if (store[i]) begin
                        q_idx[alloc_slot[i]]  <= lane_idx[i];
                        q_data[alloc_slot[i]] <= lane_data[i];
                    end
                end
                if (pop)
                    rd_ptr <= PTR_W'((int'(rd_ptr) + 1) % QUEUE_DEPTH);
                count <= count + n_alloc - CNT_W'(pop);
            end
        end
    end

`ifdef PAP_SCHED_STATS_EN
    logic [CNT_W-1:0] n_coal;
    logic [16:0]      coal_sum;

    always_comb begin
        n_coal = '0;
        for (int i = 0; i < NUM_REQ; i++)
            if ((cand[i] && !store[i]) || merge[i])
                n_coal = n_coal + CNT_W'(1);
    end

    assign coal_sum = {1'b0, coalesceCount} + 17'(n_coal);

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN)
            coalesceCount <= '0;
        else if (initStart)
            coalesceCount <= '0;
        else if (state == RUN)
            coalesceCount <= coal_sum[16] ? 16'hFFFF : coal_sum[15:0];
    end
`endif

endmodule

// File: tb/tb_pap_table_write_scheduler.sv
// Directed bench for pap_table_write_scheduler with a small RAM model.
// Build with PAP_SCHED_STATS_EN to also check coalesceCount.
module tb_pap_table_write_scheduler;
    localparam int IW = 4;
    localparam int DW = 16;
    localparam logic [15:0] IV = 16'hC3C3;

    logic          clk = 1'b0;
    logic          rstN = 1'b0;
    logic          initStart = 1'b0;
    logic          initBusy;
    logic [1:0]    reqValid = '0;
    logic [7:0]    reqIndex = '0;
    logic [31:0]   reqData = '0;
    logic          reqReady;
    logic          wrEn;
    logic [IW-1:0] wrIndex;
    logic [DW-1:0] wrData;
    logic [2:0]    queueCount;
`ifdef PAP_SCHED_STATS_EN
    logic [15:0]   coalesceCount;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    int w7 = 0;
    int w7_base;
    int n6060 = 0;
    logic [15:0] ram [16];

    pap_table_write_scheduler #(
        .ENTRY_NUM(16), .INDEX_W(IW), .DATA_W(DW),
        .NUM_REQ(2), .QUEUE_DEPTH(4), .INIT_VALUE(IV)
    ) dut (
        .clk(clk), .rstN(rstN), .initStart(initStart),
        .initBusy(initBusy), .reqValid(reqValid),
        .reqIndex(reqIndex), .reqData(reqData),
        .reqReady(reqReady), .wrEn(wrEn),
        .wrIndex(wrIndex), .wrData(wrData),
`ifdef PAP_SCHED_STATS_EN
        .coalesceCount(coalesceCount),
`endif
        .queueCount(queueCount)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rstN && wrEn) begin
            ram[wrIndex] <= wrData;
            if (wrIndex == 4'd7) w7 <= w7 + 1;
            if (wrData == 16'h6060) n6060 <= n6060 + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic drive(input logic [1:0] v, input logic [3:0] i0,
                         input logic [15:0] d0, input logic [3:0] i1,
                         input logic [15:0] d1, input logic st);
        reqValid  = v;
        reqIndex  = {i1, i0};
        reqData   = {d1, d0};
        initStart = st;
        #1;
    endtask

    task automatic idle();
        drive(2'b00, 4'd0, 16'h0, 4'd0, 16'h0, 1'b0);
    endtask

    task automatic wr(input string tag, input logic [3:0] i,
                      input logic [15:0] d);
        check({tag, "_en"}, wrEn, 1);
        check({tag, "_idx"}, wrIndex, i);
        check({tag, "_dat"}, wrData, d);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        #2;
        check("rst_wren", wrEn, 0);
        check("rst_idx", wrIndex, 0);
        check("rst_dat", wrData, 0);
        check("rst_ready", reqReady, 0);
        check("rst_busy", initBusy, 1);
        check("rst_cnt", queueCount, 0);
        @(negedge clk);
        @(negedge clk);
        rstN = 1'b1;

        // Sweep with requests held valid: they must be ignored.
        for (int c = 0; c < 16; c++) begin
            if (c > 0) step();
            drive(2'b11, 4'd2, 16'hDEAD, 4'd2, 16'hBEEF, 1'b0);
            wr("sweep", 4'(c), IV);
            check("sweep_ready", reqReady, 0);
            check("sweep_busy", initBusy, 1);
        end
        check("sweep_cnt", queueCount, 0);
        step(); idle();
        check("run_busy", initBusy, 0);
        check("run_ready", reqReady, 1);
        check("run_wren", wrEn, 0);
        check("hold_idx", wrIndex, 15);
        check("hold_dat", wrData, IV);
        check("ram2_init", ram[2], IV);

        // Bypass lane0, lane1 queued.
        step(); drive(2'b11, 4'd5, 16'hAAAA, 4'd9, 16'hBBBB, 1'b0);
        wr("byp", 4'd5, 16'hAAAA);
        check("byp_cnt", queueCount, 0);
        step(); idle();
        wr("byp_q", 4'd9, 16'hBBBB);
        check("byp_cnt1", queueCount, 1);
        step();
        check("byp_cnt0", queueCount, 0);
        check("byp_idle", wrEn, 0);
        check("ram5", ram[5], 16'hAAAA);
        check("ram9", ram[9], 16'hBBBB);

        // Same index on both lanes for three cycles.
        step(); drive(2'b11, 4'd3, 16'h1111, 4'd3, 16'h2222, 1'b0);
        wr("dup0", 4'd3, 16'h1111);
        step(); drive(2'b11, 4'd3, 16'h1111, 4'd3, 16'h2222, 1'b0);
        wr("dup1", 4'd3, 16'h2222);
        check("dup1_cnt", queueCount, 1);
        step(); drive(2'b11, 4'd3, 16'h1111, 4'd3, 16'h2222, 1'b0);
        wr("dup2", 4'd3, 16'h2222);
        check("dup2_cnt", queueCount, 1);
        step(); idle();
        wr("dup3", 4'd3, 16'h2222);
        check("dup3_cnt", queueCount, 1);
        step();
        check("dup_cnt0", queueCount, 0);
        check("dup_idle", wrEn, 0);
        check("ram3", ram[3], 16'h2222);
`ifdef PAP_SCHED_STATS_EN
        check("stat_dup", coalesceCount, 2);
`endif

        // Fill to 3 entries, then lanes are dropped.
        step(); drive(2'b11, 4'd1, 16'h0101, 4'd2, 16'h0202, 1'b0);
        wr("fill0", 4'd1, 16'h0101);
        step(); drive(2'b11, 4'd4, 16'h0404, 4'd6, 16'h0606, 1'b0);
        wr("fill1", 4'd2, 16'h0202);
        check("fill1_cnt", queueCount, 1);
        step(); drive(2'b11, 4'd8, 16'h0808, 4'd10, 16'h0A0A, 1'b0);
        wr("fill2", 4'd4, 16'h0404);
        check("fill2_cnt", queueCount, 2);
        check("fill2_ready", reqReady, 1);
        step(); drive(2'b11, 4'd11, 16'h0B0B, 4'd12, 16'h0C0C, 1'b0);
        wr("fill3", 4'd6, 16'h0606);
        check("fill3_cnt", queueCount, 3);
        check("full_ready", reqReady, 0);
        step(); idle();
        wr("fill4", 4'd8, 16'h0808);
        check("fill4_cnt", queueCount, 2);
        check("fill4_ready", reqReady, 1);
        step();
        wr("fill5", 4'd10, 16'h0A0A);
        check("fill5_cnt", queueCount, 1);
        step();
        check("fill_cnt0", queueCount, 0);
        check("ram11", ram[11], IV);
        check("ram12", ram[12], IV);
        check("ram10", ram[10], 16'h0A0A);

        // In-queue coalesce on a non-head entry.
        w7_base = w7;
        step(); drive(2'b11, 4'd13, 16'h0D0D, 4'd14, 16'h0E0E, 1'b0);
        wr("co0", 4'd13, 16'h0D0D);
        step(); drive(2'b11, 4'd15, 16'h0F0F, 4'd7, 16'h0001, 1'b0);
        wr("co1", 4'd14, 16'h0E0E);
        step(); drive(2'b11, 4'd7, 16'h0002, 4'd1, 16'h1111, 1'b0);
        wr("co2", 4'd15, 16'h0F0F);
        check("co2_cnt", queueCount, 2);
        step(); idle();
        check("co3_cnt", queueCount, 2);
        wr("co3", 4'd7, 16'h0002);
        step();
        wr("co4", 4'd1, 16'h1111);
        step();
        check("co_cnt0", queueCount, 0);
        check("co_w7", w7 - w7_base, 1);
        check("ram7", ram[7], 16'h0002);
`ifdef PAP_SCHED_STATS_EN
        check("stat_co", coalesceCount, 3);
`endif

        // initStart with two queued entries.
        step(); drive(2'b11, 4'd2, 16'h2020, 4'd4, 16'h4040, 1'b0);
        wr("is0", 4'd2, 16'h2020);
        step(); drive(2'b11, 4'd5, 16'h5050, 4'd6, 16'h6060, 1'b0);
        wr("is1", 4'd4, 16'h4040);
        step(); drive(2'b00, 4'd0, 16'h0, 4'd0, 16'h0, 1'b1);
        check("is2_cnt", queueCount, 2);
        wr("is2", 4'd5, 16'h5050);
        for (int c = 0; c < 16; c++) begin
            step(); idle();
            check("resweep_cnt", queueCount, 0);
            check("resweep_busy", initBusy, 1);
            wr("resweep", 4'(c), IV);
        end
`ifdef PAP_SCHED_STATS_EN
        check("stat_clr", coalesceCount, 0);
`endif
        step();
        check("resweep_done", initBusy, 0);
        check("no_6060", n6060, 0);
        check("ram5_swept", ram[5], IV);

        // Async reset with a pending entry.
        step(); drive(2'b11, 4'd8, 16'h8888, 4'd9, 16'h9999, 1'b0);
        step(); idle();
        check("pre_rst_cnt", queueCount, 1);
        #1 rstN = 1'b0;
        #1;
        check("mid_rst_cnt", queueCount, 0);
        check("mid_rst_wren", wrEn, 0);
        check("mid_rst_busy", initBusy, 1);
        check("mid_rst_ready", reqReady, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
